// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and defaults for the LED PWM path.
//   state_t           - breath sequencer FSM states (3-bit encoding, also the debug port value)
//   DUTY_MAX_DEFAULT  - full-scale duty shared with the PWM generator (counter range 0..100)
//   DUTY_W_DEFAULT    - duty/level width, wide enough to hold DUTY_MAX_DEFAULT
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP      = 3'd1,
        HOLD_HI = 3'd2,
        DOWN    = 3'd3,
        HOLD_LO = 3'd4,
        OFF     = 3'd5
    } state_t;

    localparam int DUTY_MAX_DEFAULT = 100;
    localparam int DUTY_W_DEFAULT   = 8;

endpackage

// File: rtl/pwm_gamma_lut.sv
// pwm_gamma_lut: combinational level -> perceptual duty map,
// gamma = floor(level*level/DUTY_MAX), built as a constant table at elaboration.
// Ports:
//   level  in  DUTY_W  linear brightness level (0..DUTY_MAX)
//   gamma  out DUTY_W  corrected duty; levels above DUTY_MAX saturate to DUTY_MAX
module pwm_gamma_lut #(
    parameter int DUTY_W   = 8,
    parameter int DUTY_MAX = 100
) (
    input  logic [DUTY_W-1:0] level,
    output logic [DUTY_W-1:0] gamma
);

    logic [DUTY_W-1:0] lut [DUTY_MAX+1];

    for (genvar i = 0; i <= DUTY_MAX; i++) begin : g_lut
        assign lut[i] = DUTY_W'((i * i) / DUTY_MAX);
    end

    always_comb begin
        gamma = DUTY_W'(DUTY_MAX);
        for (int i = 0; i <= DUTY_MAX; i++) begin
            if (level == DUTY_W'(i)) gamma = lut[i];
        end
    end

endmodule

// File: rtl/pwm_breath_ctrl.sv
// pwm_breath_ctrl: breathing duty sequencer feeding the PWM stage.
// Profile: ramp up by STEP per step tick to DUTY_MAX, hold HOLD_STEPS ticks,
// ramp down to 0, hold HOLD_STEPS ticks, repeat. Step ticks come from a
// STEP_DIV prescaler that freezes while a duty value waits for acceptance.
// Optional gamma correction: define PWM_BREATH_GAMMA_EN to map each level
// through pwm_gamma_lut before it is registered into duty.
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   async reset, active low
//   en          in   sequencer enable (level); dropping it parks duty at 0
//   duty        out  duty value presented to the PWM stage
//   duty_valid  out  duty holds a new, not-yet-accepted value
//   duty_ready  in   PWM stage accepts duty this cycle
//   state       out  FSM state encoding (debug)
//   cycle_done  out  one-clock pulse at the end of each breath cycle
module pwm_breath_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_W     = DUTY_W_DEFAULT,
    parameter int DUTY_MAX   = DUTY_MAX_DEFAULT,
    parameter int STEP       = 1,
    parameter int STEP_DIV   = 1000,
    parameter int HOLD_STEPS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_valid,
    input  logic              duty_ready,
    output logic [2:0]        state,
    output logic              cycle_done
);

    localparam int PW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int HW = $clog2(HOLD_STEPS + 1);

    state_t            state_q, state_n;
    logic [PW-1:0]     pre_q, pre_n;
    logic [HW-1:0]     hold_q, hold_n;
    logic [DUTY_W-1:0] level_q, level_n;
    logic [DUTY_W-1:0] duty_q, duty_n;
    logic              valid_q, valid_n;
    logic              done_q, done_n;

    logic              xfer, tick, load, hold_last;
    logic [DUTY_W:0]   up_sum;
    logic [DUTY_W-1:0] up_lvl, dn_lvl, step_lvl, step_duty;

    assign xfer      = valid_q && duty_ready;
    // A pending, unaccepted value stalls the step; the prescaler sits at
    // its terminal count so the step fires as soon as the value is taken.
    assign tick      = (pre_q == PW'(STEP_DIV - 1)) && !(valid_q && !duty_ready);
    assign hold_last = (hold_q == HW'(HOLD_STEPS - 1));

    // One extra bit on the sum so saturation sees the true value.
    assign up_sum   = {1'b0, level_q} + (DUTY_W+1)'(STEP);
    assign up_lvl   = (up_sum >= (DUTY_W+1)'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : up_sum[DUTY_W-1:0];
    assign dn_lvl   = (level_q <= DUTY_W'(STEP)) ? '0 : level_q - DUTY_W'(STEP);
    assign step_lvl = (state_q == DOWN) ? dn_lvl : up_lvl;

`ifdef PWM_BREATH_GAMMA_EN
    pwm_gamma_lut #(
        .DUTY_W   (DUTY_W),
        .DUTY_MAX (DUTY_MAX)
    ) u_gamma (
        .level (step_lvl),
        .gamma (step_duty)
    );
`else
    assign step_duty = step_lvl;
`endif

    always_comb begin
        state_n = state_q;
        pre_n   = pre_q;
        hold_n  = hold_q;
        level_n = level_q;
        duty_n  = duty_q;
        valid_n = valid_q;
        done_n  = 1'b0;
        load    = 1'b0;

        if (state_q == IDLE)              pre_n = '0;
        else if (pre_q == PW'(STEP_DIV - 1)) begin
            if (tick) pre_n = '0;
        end else                          pre_n = pre_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_n = UP;
                    level_n = '0;
                    hold_n  = '0;
                end
            end
            UP: begin
                if (tick) begin
                    level_n = up_lvl;
                    load    = 1'b1;
                    if (up_lvl == DUTY_W'(DUTY_MAX)) state_n = HOLD_HI;
                end
            end
            HOLD_HI: begin
                if (tick) begin
                    if (hold_last) begin
                        hold_n  = '0;
                        state_n = DOWN;
                    end else hold_n = hold_q + 1'b1;
                end
            end
            DOWN: begin
                if (tick) begin
                    level_n = dn_lvl;
                    load    = 1'b1;
                    if (dn_lvl == '0) state_n = HOLD_LO;
                end
            end
            HOLD_LO: begin
                if (tick) begin
                    if (hold_last) begin
                        hold_n  = '0;
                        done_n  = 1'b1;
                        state_n = UP;
                    end else hold_n = hold_q + 1'b1;
                end
            end
            OFF: begin
                if (xfer) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Disable wins over any step in flight: park the PWM at 0 and
        // overwrite whatever value was still waiting.
        if (!en && state_q != IDLE && state_q != OFF) begin
            state_n = OFF;
            level_n = '0;
            hold_n  = '0;
            done_n  = 1'b0;
            duty_n  = '0;
            valid_n = 1'b1;
        end else if (load) begin
            duty_n  = step_duty;
            valid_n = 1'b1;
        end else if (xfer) begin
            valid_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            hold_q  <= '0;
            level_q <= '0;
            duty_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            pre_q   <= pre_n;
            hold_q  <= hold_n;
            level_q <= level_n;
            duty_q  <= duty_n;
            valid_q <= valid_n;
            done_q  <= done_n;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = valid_q;
    assign state      = state_q;
    assign cycle_done = done_q;

endmodule
